// File: rtl/bus_pkg.sv
// bus_pkg: shared constants and state encoding for the line-granular bus responder
package bus_pkg;
  localparam int BEATS_PER_LINE = 8;
  localparam int LINE_BITS = 512;
  localparam int REQTAG_READ_BIT = 12;
  typedef enum logic [2:0] {IDLE, WDATA, RLAT, RSTREAM, RDRAIN} state_t;
endpackage

// File: rtl/bus_line_responder_if.sv
// bus_line_responder_if: request/response line bus between a cache initiator and a memory responder
interface bus_line_responder_if #(parameter int DW = 64, parameter int TW = 13);
  logic          reqcyc;
  logic [DW-1:0] req;
  logic [TW-1:0] reqtag;
  logic          reqack;
  logic          respcyc;
  logic [DW-1:0] resp;
  logic [TW-1:0] resptag;
  logic          respack;
  modport master (output reqcyc, req, reqtag, respack, input reqack, respcyc, resp, resptag);
  modport slave (input reqcyc, req, reqtag, respack, output reqack, respcyc, resp, resptag);
endinterface

// File: rtl/bus_line_store.sv
// bus_line_store: line-wide backing store with a beat-select write port and a beat read port
module bus_line_store import bus_pkg::*; #(
  parameter int DW = 64,
  parameter int LOG_NUM_LINES = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [LOG_NUM_LINES-1:0] wr_idx,
  input  logic [2:0]               wr_beat,
  input  logic [DW-1:0]            wr_data,
  input  logic [LOG_NUM_LINES-1:0] rd_idx,
  input  logic [2:0]               rd_beat,
  output logic [DW-1:0]            rd_data
);
  logic [BEATS_PER_LINE*DW-1:0] mem [1<<LOG_NUM_LINES];
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < (1 << LOG_NUM_LINES); i++) mem[i] <= '0;
    else if (we) mem[wr_idx][int'(wr_beat)*DW +: DW] <= wr_data;
  assign rd_data = mem[rd_idx][int'(rd_beat)*DW +: DW];
endmodule

// File: rtl/bus_line_responder.sv
// bus_line_responder: memory-side responder serving read-line and write-line transactions
module bus_line_responder import bus_pkg::*; #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int LOG_NUM_LINES = 6,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_line_responder_if.slave  bus,
  output logic                 busy,
  output logic                 err_protocol
);
  state_t                    state;
  logic [BUS_TAG_WIDTH-1:0]  tag;
  logic [LOG_NUM_LINES-1:0]  idx, rd_idx;
  logic [2:0]                beat;
  logic [15:0]               lat;
  logic [3:0]                sent, acks, acks_n;
  logic                      ack_ok, we;
  logic [BUS_DATA_WIDTH-1:0] rd_data;
  assign busy = state != IDLE;
  assign ack_ok = bus.respack && acks < sent;
  assign acks_n = acks + {3'b0, ack_ok};
  assign we = state == WDATA && bus.reqack;
  // the address beat indexes the store directly so a 1-cycle latency read can fetch beat 0 at once
  assign rd_idx = state == IDLE ? bus.req[LOG_NUM_LINES+5:6] : idx;
  bus_line_store #(.DW(BUS_DATA_WIDTH), .LOG_NUM_LINES(LOG_NUM_LINES)) u_store (
    .clk(clk), .reset(reset), .we(we), .wr_idx(idx), .wr_beat(beat), .wr_data(bus.req),
    .rd_idx(rd_idx), .rd_beat(beat), .rd_data(rd_data)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.reqack <= 1'b0;
      bus.respcyc <= 1'b0;
      bus.resp <= '0;
      bus.resptag <= '0;
      tag <= '0;
      idx <= '0;
      beat <= '0;
      lat <= '0;
      sent <= '0;
      acks <= '0;
      err_protocol <= 1'b0;
    end else begin
      bus.reqack <= (state == IDLE || state == WDATA) && bus.reqcyc && !bus.reqack;
      sent <= sent + {3'b0, bus.respcyc};
      acks <= acks_n;
      // an ack with nothing outstanding (including a ninth ack) is a protocol violation
      err_protocol <= err_protocol || (bus.respack && !ack_ok);
      case (state)
        IDLE: if (bus.reqack) begin
          tag <= bus.reqtag;
          idx <= rd_idx;
          beat <= '0;
          sent <= '0;
          acks <= '0;
          if (!bus.reqtag[REQTAG_READ_BIT]) state <= WDATA;
          else if (MEM_LATENCY > 1) begin
            state <= RLAT;
            lat <= 16'(MEM_LATENCY - 1);
          end else begin
            state <= RSTREAM;
            bus.respcyc <= 1'b1;
            bus.resp <= rd_data;
            bus.resptag <= bus.reqtag;
            beat <= 3'd1;
          end
        end
        RLAT: if (lat == 16'd1) begin
          state <= RSTREAM;
          bus.respcyc <= 1'b1;
          bus.resp <= rd_data;
          bus.resptag <= tag;
          beat <= 3'd1;
        end else lat <= lat - 16'd1;
        // beat wraps to 0 once beat 7 is on the bus, marking the end of the stream
        RSTREAM: if (beat == 3'd0) begin
          state <= RDRAIN;
          bus.respcyc <= 1'b0;
          bus.resp <= '0;
          bus.resptag <= '0;
        end else begin
          bus.resp <= rd_data;
          beat <= beat + 3'd1;
        end
        RDRAIN: if (acks_n == 4'd8) state <= IDLE;
        WDATA: if (bus.reqack) begin
          beat <= beat + 3'd1;
          if (beat == 3'd7) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bus_line_responder.md
Name: bus_line_responder

Overview:
- Memory-side responder for the line-granular request/response bus that the data cache drives as initiator.
- Accepts read-line and write-line (writeback) transactions on the request channel.
- Holds lines in an internal backing store; returns read lines as 8 x 64-bit beats on the response channel.
- Serves as the memory endpoint for cache unit and system benches; also usable as a small on-chip line memory.

Parameters:
- BUS_DATA_WIDTH, 64, width of one request/response beat.
- BUS_TAG_WIDTH, 13, request/response tag width; bit 12 is read(1)/write(0).
- LOG_NUM_LINES, 6, log2 of backing-store depth in 64-byte lines.
- MEM_LATENCY, 4, cycles from the read address-beat ack to the first response beat; must be at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- bus_reqcyc  in  1  initiator presents a request beat.
- bus_req  in  64  address beat (line address, bits [5:0] ignored) or write data beat.
- bus_reqtag  in  13  request tag; sampled on the address beat only.
- bus_reqack  out  1  one-cycle pulse; a beat was accepted.
- bus_respcyc  out  1  response beat valid.
- bus_resp  out  64  response data beat.
- bus_resptag  out  13  echoed tag of the read being answered.
- bus_respack  in  1  initiator acknowledges one consumed beat; may lag the beat by 1 or more cycles.
- busy  out  1  high whenever state is not IDLE.
- err_protocol  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset: state IDLE; all outputs 0; beat and ack counters 0; backing store cleared to 0.
- Line index is bus_req[LOG_NUM_LINES+5:6]. Upper address bits are ignored, so addresses alias.
- Beat k (0..7) maps to line bits [k*64 +: 64], for both writes and reads.
- Request beat handshake:
  - In an accepting state (IDLE, WDATA), reqcyc sampled 1 at edge t sets reqack=1 during cycle t+1.
  - bus_req/bus_reqtag are captured at the edge ending t+1.
  - reqack returns to 0 in t+2 and is never high two cycles in a row, so each beat costs at least 2 cycles.
- IDLE: on an accepted beat, latch tag and index.
  - tag[12]=1 goes to RLAT with the latency counter set to MEM_LATENCY-1.
  - tag[12]=0 goes to WDATA with the beat counter set to 0.
- WDATA:
  - Each accepted beat writes its 64 bits into beat slot k and increments k.
  - After the 8th beat, return to IDLE.
  - Writes produce no response beats.
- RLAT: decrement the counter each cycle; at 0 go to RSTREAM.
- RSTREAM:
  - respcyc=1 for exactly 8 consecutive cycles, beats 0..7 in order.
  - resptag = latched tag throughout; no stalls.
  - Then go to RDRAIN with respcyc=0 and resp=0.
- RDRAIN / ack accounting:
  - A 4-bit counter counts respack pulses from entry into RSTREAM.
  - Once 8 respacks have been counted, go to IDLE.
  - reqcyc is ignored (no reqack) in RLAT, RSTREAM and RDRAIN.
- err_protocol is set if:
  - respack is high while no read beats are outstanding (ack count equals beats sent), or
  - a 9th respack arrives.
- Read of a line is fully ordered after any completed write to it; there is no bypass, since only one transaction is ever in flight.
- Reset mid-transaction: immediate return to IDLE. A partially written line is lost because the store is cleared. In-flight response beats stop the cycle after the reset edge.
- reqcyc dropped mid-WDATA: the responder waits in WDATA indefinitely; there is no timeout.

Decomposition:
- Package bus_pkg:
  - BEATS_PER_LINE=8, LINE_BITS=512, REQTAG_READ_BIT=12.
  - State enum {IDLE, WDATA, RLAT, RSTREAM, RDRAIN}.
- Sub-module bus_line_store: NUM_LINES x 512 storage with a single 64-bit beat-select write port, a 64-bit beat read port, and synchronous clear on reset.
- Control FSM, counters and handshake stay in bus_line_responder.

Test Plan:
- Read after reset: address 0x1C0, tag 0x1103 → reqack one cycle after reqcyc; first respcyc exactly MEM_LATENCY cycles after that reqack; 8 beats of 0 with resptag 0x1103; busy drops after the 8th respack.
- Write then read: write address 0x40, tag 0x0103, data beats 0x1111_0000_0000_000k for k=0..7, each acked once with a gap cycle → then read 0x40 returns the same 8 beats in order.
- Aliasing: write index 5 via address 0x140, then read address (1<<12)|0x140 → same data returned.
- Delayed respack: respack held off 3 cycles, then pulsed 8 times → stays in RDRAIN, new reqcyc not acked until the 8th respack; err_protocol stays 0.
- Spurious respack in IDLE → err_protocol=1 next cycle and stays set until reset.
- Reset after 4 of 8 write beats → reqack/busy 0 next cycle; subsequent read of that line returns all zeros.
